led_pattern_ctrl: RTL and testbench

Sequencing controller for the LED display path. It owns the step timer and the LED pattern register, and steps a NO_LEDS-wide array through four selectable patterns. Step rate comes from a 4-level speed setting. Sits between the board push-buttons/switches and the LED pins; it is the multi-mode successor to the single-pattern snake.

---
 rtl/led_pattern_ctrl.sv | 222 ++++++++++++++++++++++
 tb/tb_led_pattern_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer: four selectable patterns stepped by a speed-scaled timer.
// Define LED_PATTERN_CTRL_DEBOUNCE_EN to insert a per-button debounce filter.
module led_pattern_ctrl #(
  parameter int FREQ            = 50_000_000,
  parameter int STEP_CYCLES     = 12_500_000,
  parameter int NO_LEDS         = 10,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               en_i,
  input  logic               mode_next_i,
  input  logic               speed_up_i,
  input  logic               speed_dn_i,
  output logic [NO_LEDS-1:0] led_array_o,
  output logic [1:0]         mode_o,
  output logic [1:0]         speed_o,
  output logic               tick_o
);

  typedef enum logic [1:0] {
    SNAKE_L = 2'd0,
    SNAKE_R = 2'd1,
    BOUNCE  = 2'd2,
    FILL    = 2'd3
  } mode_t;

  localparam int TMR_W    = $clog2(8 * STEP_CYCLES);
  localparam int BTN_MODE = 0;
  localparam int BTN_UP   = 1;
  localparam int BTN_DN   = 2;

  localparam logic [TMR_W-1:0] PM1_SPD0 = TMR_W'(8 * STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PM1_SPD1 = TMR_W'(4 * STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PM1_SPD2 = TMR_W'(2 * STEP_CYCLES - 1);
  localparam logic [TMR_W-1:0] PM1_SPD3 = TMR_W'(STEP_CYCLES - 1);

  if (NO_LEDS < 2 || STEP_CYCLES < 1 || FREQ < 1 || DEBOUNCE_CYCLES < 1) begin : g_param_chk
    $error("led_pattern_ctrl: illegal parameter value");
  end

  function automatic logic [TMR_W-1:0] period_m1(input logic [1:0] spd);
    logic [TMR_W-1:0] r;
    case (spd)
      2'd0:    r = PM1_SPD0;
      2'd1:    r = PM1_SPD1;
      2'd2:    r = PM1_SPD2;
      default: r = PM1_SPD3;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] sat_speed(input logic [1:0] spd, input logic up);
    logic [1:0] r;
    if (up) r = (spd == 2'd3) ? spd : spd + 2'd1;
    else    r = (spd == 2'd0) ? spd : spd - 2'd1;
    return r;
  endfunction

  function automatic mode_t next_mode(input mode_t m);
    mode_t r;
    case (m)
      SNAKE_L: r = SNAKE_R;
      SNAKE_R: r = BOUNCE;
      BOUNCE:  r = FILL;
      default: r = SNAKE_L;
    endcase
    return r;
  endfunction

  function automatic logic [NO_LEDS-1:0] start_pattern(input mode_t m);
    logic [NO_LEDS-1:0] r;
    case (m)
      SNAKE_R: r = {1'b1, {(NO_LEDS-1){1'b0}}};
      FILL:    r = '0;
      default: r = NO_LEDS'(1);
    endcase
    return r;
  endfunction

  function automatic logic [NO_LEDS-1:0] step_pattern(input mode_t m,
                                                      input logic [NO_LEDS-1:0] l,
                                                      input logic up);
    logic [NO_LEDS-1:0] r;
    case (m)
      SNAKE_L: r = {l[NO_LEDS-2:0], l[NO_LEDS-1]};
      SNAKE_R: r = {l[0], l[NO_LEDS-1:1]};
      BOUNCE:  r = up ? {l[NO_LEDS-2:0], 1'b0} : {1'b0, l[NO_LEDS-1:1]};
      default: r = (&l) ? '0 : {l[NO_LEDS-2:0], 1'b1};
    endcase
    return r;
  endfunction

  logic [2:0] btn_raw;
  logic [2:0] sync_p0, sync_p1;
  logic [2:0] lvl_p1;
  logic [2:0] prev_p2, evt_p2;

  assign btn_raw = {speed_dn_i, speed_up_i, mode_next_i};

  // stage p0/p1: two-flop synchronizer for the asynchronous buttons
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

`ifdef LED_PATTERN_CTRL_DEBOUNCE_EN
  localparam int DBC_W = $clog2(DEBOUNCE_CYCLES + 1);

  for (genvar b = 0; b < 3; b++) begin : g_dbc
    logic [DBC_W-1:0] cnt;
    logic             filt;

    // Any return to the filtered level restarts the stability count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt  <= '0;
        filt <= 1'b0;
      end else if (sync_p1[b] == filt) begin
        cnt <= '0;
      end else if (cnt == DBC_W'(DEBOUNCE_CYCLES - 1)) begin
        cnt  <= '0;
        filt <= sync_p1[b];
      end else begin
        cnt <= cnt + DBC_W'(1);
      end
    end

    assign lvl_p1[b] = filt;
  end
`else
  assign lvl_p1 = sync_p1;
`endif

  // stage p2: registered rising-edge events
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_p2 <= '0;
      evt_p2  <= '0;
    end else begin
      prev_p2 <= lvl_p1;
      evt_p2  <= lvl_p1 & ~prev_p2;
    end
  end

  mode_t              mode_q, mode_d;
  logic [NO_LEDS-1:0] led_q, led_d;
  logic               dir_up_q, dir_up_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         speed_q, speed_d;
  logic               tick_q, tick_d;
  logic               spd_up, spd_dn;

  // Opposing speed events in one cycle cancel each other.
  assign spd_up = evt_p2[BTN_UP] & ~evt_p2[BTN_DN];
  assign spd_dn = evt_p2[BTN_DN] & ~evt_p2[BTN_UP];

  // stage p3: mode FSM, speed, step timer and pattern register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= SNAKE_L;
      led_q    <= NO_LEDS'(1);
      dir_up_q <= 1'b1;
      timer_q  <= '0;
      speed_q  <= 2'd1;
      tick_q   <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      led_q    <= led_d;
      dir_up_q <= dir_up_d;
      timer_q  <= timer_d;
      speed_q  <= speed_d;
      tick_q   <= tick_d;
    end
  end

  always_comb begin
    mode_d   = mode_q;
    led_d    = led_q;
    dir_up_d = dir_up_q;
    timer_d  = timer_q;
    speed_d  = speed_q;
    tick_d   = 1'b0;

    if (spd_up || spd_dn) begin
      speed_d = sat_speed(speed_q, spd_up);
    end

    // A mode reload wins over a timer expiry in the same cycle: no step, no tick.
    if (evt_p2[BTN_MODE]) begin
      mode_d   = next_mode(mode_q);
      led_d    = start_pattern(mode_d);
      dir_up_d = 1'b1;
      timer_d  = '0;
    end else if (speed_d != speed_q) begin
      timer_d = '0;
    end else if (en_i) begin
      if (timer_q == period_m1(speed_q)) begin
        timer_d = '0;
        tick_d  = 1'b1;
        led_d   = step_pattern(mode_q, led_q, dir_up_q);
        if (mode_q == BOUNCE) begin
          if (led_d[NO_LEDS-1])  dir_up_d = 1'b0;
          else if (led_d[0])     dir_up_d = 1'b1;
        end
      end else begin
        timer_d = timer_q + TMR_W'(1);
      end
    end
  end

  assign led_array_o = led_q;
  assign mode_o      = mode_q;
  assign speed_o     = speed_q;
  assign tick_o      = tick_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl: vector table of steps and button presses plus
// hand-written freeze, collision, async-reset and (with the macro) debounce sequences.
module tb_led_pattern_ctrl;

  localparam int NO_LEDS         = 4;
  localparam int STEP_CYCLES     = 4;
  localparam int DEBOUNCE_CYCLES = 8;

  localparam int K_STEP = 0;
  localparam int K_MODE = 1;
  localparam int K_UP   = 2;
  localparam int K_DN   = 3;
  localparam int K_BOTH = 4;

  typedef struct {
    int         kind;
    logic [3:0] led;
    logic [1:0] mode;
    logic [1:0] speed;
    logic       tick;
    int         period;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       mode_next;
  logic       speed_up;
  logic       speed_dn;
  logic [3:0] led;
  logic [1:0] mode;
  logic [1:0] speed;
  logic       tick;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [1:0] cur_mode;
  logic [1:0] cur_speed;
  vec_t       tbl[$];

  led_pattern_ctrl #(
    .FREQ            (50_000_000),
    .STEP_CYCLES     (STEP_CYCLES),
    .NO_LEDS         (NO_LEDS),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .en_i        (en),
    .mode_next_i (mode_next),
    .speed_up_i  (speed_up),
    .speed_dn_i  (speed_dn),
    .led_array_o (led),
    .mode_o      (mode),
    .speed_o     (speed),
    .tick_o      (tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int k, input logic [3:0] l, input logic [1:0] m,
                     input logic [1:0] s, input logic t, input int p);
    vec_t v;
    v.kind = k; v.led = l; v.mode = m; v.speed = s; v.tick = t; v.period = p;
    tbl.push_back(v);
  endtask

  // Returns the number of clock cycles until tick is seen, bounded.
  task automatic wait_step(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!tick && cyc < 200);
  endtask

  // Two-cycle button pulse; result is due on the 4th falling edge after the rise.
  task automatic press(input int idx, input vec_t v);
    logic [2:0] b;
    case (v.kind)
      K_MODE:  b = 3'b001;
      K_UP:    b = 3'b010;
      K_DN:    b = 3'b100;
      default: b = 3'b110;
    endcase
    mode_next = b[0]; speed_up = b[1]; speed_dn = b[2];
    @(negedge clk);
    @(negedge clk);
    mode_next = 1'b0; speed_up = 1'b0; speed_dn = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d_latency_mode", idx), mode, cur_mode);
    check($sformatf("v%0d_latency_speed", idx), speed, cur_speed);
    @(negedge clk);
    check($sformatf("v%0d_press_led", idx), led, v.led);
    check($sformatf("v%0d_press_mode", idx), mode, v.mode);
    check($sformatf("v%0d_press_speed", idx), speed, v.speed);
    check($sformatf("v%0d_press_tick", idx), tick, v.tick);
    cur_mode  = v.mode;
    cur_speed = v.speed;
  endtask

  task automatic run_vectors();
    int cyc;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].kind == K_STEP) begin
        wait_step(cyc);
        check($sformatf("v%0d_step_tick", i), tick, 1);
        check($sformatf("v%0d_step_period", i), cyc, tbl[i].period);
        check($sformatf("v%0d_step_led", i), led, tbl[i].led);
        check($sformatf("v%0d_step_mode", i), mode, tbl[i].mode);
        check($sformatf("v%0d_step_speed", i), speed, tbl[i].speed);
        cur_mode  = tbl[i].mode;
        cur_speed = tbl[i].speed;
      end else begin
        press(i, tbl[i]);
      end
    end
    tbl.delete();
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0; en = 1'b1;
    mode_next = 1'b0; speed_up = 1'b0; speed_dn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_led", led, 4'b0001);
    check("reset_mode", mode, 0);
    check("reset_speed", speed, 1);
    check("reset_tick", tick, 0);
    cur_mode = 2'd0; cur_speed = 2'd1;
    rst_n = 1'b1;

`ifdef LED_PATTERN_CTRL_DEBOUNCE_EN
    mode_next = 1'b1;
    repeat (5) @(negedge clk);
    mode_next = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("glitch_mode", mode, 0);
    end
    mode_next = 1'b1;
    repeat (11) @(negedge clk);
    check("dbc_latency_mode", mode, 0);
    @(negedge clk);
    check("dbc_press_mode", mode, 1);
    check("dbc_press_led", led, 4'b1000);
    mode_next = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      check("dbc_single_event_mode", mode, 1);
    end
`else
    // SNAKE_L at speed 1
    add(K_STEP, 4'b0010, 0, 1, 1, 16);
    add(K_STEP, 4'b0100, 0, 1, 1, 16);
    add(K_STEP, 4'b1000, 0, 1, 1, 16);
    add(K_STEP, 4'b0001, 0, 1, 1, 16);
    // SNAKE_R
    add(K_MODE, 4'b1000, 1, 1, 0, 0);
    add(K_STEP, 4'b0100, 1, 1, 1, 16);
    add(K_STEP, 4'b0010, 1, 1, 1, 16);
    add(K_STEP, 4'b0001, 1, 1, 1, 16);
    add(K_STEP, 4'b1000, 1, 1, 1, 16);
    // BOUNCE
    add(K_MODE, 4'b0001, 2, 1, 0, 0);
    add(K_STEP, 4'b0010, 2, 1, 1, 16);
    add(K_STEP, 4'b0100, 2, 1, 1, 16);
    add(K_STEP, 4'b1000, 2, 1, 1, 16);
    add(K_STEP, 4'b0100, 2, 1, 1, 16);
    add(K_STEP, 4'b0010, 2, 1, 1, 16);
    add(K_STEP, 4'b0001, 2, 1, 1, 16);
    add(K_STEP, 4'b0010, 2, 1, 1, 16);
    // FILL
    add(K_MODE, 4'b0000, 3, 1, 0, 0);
    add(K_STEP, 4'b0001, 3, 1, 1, 16);
    add(K_STEP, 4'b0011, 3, 1, 1, 16);
    add(K_STEP, 4'b0111, 3, 1, 1, 16);
    add(K_STEP, 4'b1111, 3, 1, 1, 16);
    add(K_STEP, 4'b0000, 3, 1, 1, 16);
    add(K_MODE, 4'b0001, 0, 1, 0, 0);
    // speed up to saturation; the rejected third press lets the timer expire
    add(K_UP,   4'b0001, 0, 2, 0, 0);
    add(K_UP,   4'b0001, 0, 3, 0, 0);
    add(K_UP,   4'b0010, 0, 3, 1, 0);
    add(K_STEP, 4'b0100, 0, 3, 1, 4);
    add(K_STEP, 4'b1000, 0, 3, 1, 4);
    // speed down to saturation; first press coincides with an expiring timer
    add(K_DN,   4'b1000, 0, 2, 0, 0);
    add(K_DN,   4'b1000, 0, 1, 0, 0);
    add(K_DN,   4'b1000, 0, 0, 0, 0);
    add(K_DN,   4'b1000, 0, 0, 0, 0);
    add(K_DN,   4'b1000, 0, 0, 0, 0);
    add(K_STEP, 4'b0001, 0, 0, 1, 24);
    add(K_STEP, 4'b0010, 0, 0, 1, 32);
    add(K_BOTH, 4'b0010, 0, 0, 0, 0);
    add(K_STEP, 4'b0100, 0, 0, 1, 28);
    // back to speed 3, then a mode event on the expiring cycle
    add(K_UP,   4'b0100, 0, 1, 0, 0);
    add(K_UP,   4'b0100, 0, 2, 0, 0);
    add(K_UP,   4'b0100, 0, 3, 0, 0);
    add(K_STEP, 4'b1000, 0, 3, 1, 4);
    add(K_STEP, 4'b0001, 0, 3, 1, 4);
    add(K_MODE, 4'b1000, 1, 3, 0, 0);
    add(K_STEP, 4'b0100, 1, 3, 1, 4);
    run_vectors();

    // freeze with the timer part-way through a period
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      check("freeze_led", led, 4'b0100);
      check("freeze_tick", tick, 0);
    end
    en = 1'b1;
    wait_step(cyc);
    check("unfreeze_tick", tick, 1);
    check("unfreeze_period", cyc, 2);
    check("unfreeze_led", led, 4'b0010);

    // mode event accepted while disabled, then BOUNCE up and back down
    en = 1'b0;
    add(K_MODE, 4'b0001, 2, 3, 0, 0);
    run_vectors();
    en = 1'b1;
    add(K_STEP, 4'b0010, 2, 3, 1, 4);
    add(K_STEP, 4'b0100, 2, 3, 1, 4);
    add(K_STEP, 4'b1000, 2, 3, 1, 4);
    add(K_STEP, 4'b0100, 2, 3, 1, 4);
    run_vectors();

    // asynchronous reset between clock edges
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_led", led, 4'b0001);
    check("async_rst_mode", mode, 0);
    check("async_rst_speed", speed, 1);
    check("async_rst_tick", tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cur_mode = 2'd0; cur_speed = 2'd1;
    add(K_STEP, 4'b0010, 0, 1, 1, 16);
    add(K_STEP, 4'b0100, 0, 1, 1, 16);
    run_vectors();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
